// File: rtl/word_serializer.sv
// ============================================================================
// word_serializer : parallel-in, serial-out stage with a one-word holding buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module word_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_SHIFT = 1'b1;
    localparam logic [CW-1:0] c_last  = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_hb;
    logic             r_hb_full;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_sr_out;
    logic             w_accept;
    logic             w_at_last;

    assign w_accept  = din_valid && !r_hb_full;
    assign w_at_last = (r_cnt == c_last);

    // The output end of SR is the MSB or LSB depending on bit order
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
            assign w_sr_out     = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
            assign w_sr_out     = r_sr[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (en && w_at_last && !r_hb_full && !w_accept) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr      <= '0;
            r_hb      <= '0;
            r_hb_full <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_sr  <= din;
                r_cnt <= '0;
            end
        end else if (!en || !w_at_last) begin
            if (en) begin
                r_sr  <= w_sr_shifted;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_hb      <= din;
                r_hb_full <= 1'b1;
            end
        end else begin
            // Word boundary: a buffered word takes priority over a fresh offer
            r_cnt <= '0;
            if (r_hb_full) begin
                r_sr      <= r_hb;
                r_hb_full <= 1'b0;
            end else if (w_accept) begin
                r_sr <= din;
            end
        end
    end

    always_comb begin
        din_ready  = !r_hb_full;
        sout       = IDLE_BIT;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        busy       = r_hb_full;
        if (r_state == S_SHIFT) begin
            sout       = w_sr_out;
            sout_valid = 1'b1;
            sout_last  = w_at_last;
            busy       = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_word_serializer.sv
// ============================================================================
// tb_word_serializer : scoreboard bench for MSB-first and LSB-first serializers
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_word_serializer;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_valid = 1'b0;
    logic         en        = 1'b1;

    logic m_ready, m_sout, m_sv, m_sl, m_busy;
    logic l_ready, l_sout, l_sv, l_sl, l_busy;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
        .en(en), .sout(m_sout), .sout_valid(m_sv), .sout_last(m_sl), .busy(m_busy)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
        .en(en), .sout(l_sout), .sout_valid(l_sv), .sout_last(l_sl), .busy(l_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t qm[$];
    exp_t ql[$];

    int   n_vec = 0;
    int   n_err = 0;
    bit   throttle = 1'b0;
    int   cyc = 0;

    bit       det_on = 1'b0;
    logic [3:0] hist = '0;
    int       nbits  = 0;
    int       npulse = 0;
    int       ppos0  = 0;
    int       ppos1  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back('{b: w[W-1-i], last: (i == W-1)});
            ql.push_back('{b: w[i],     last: (i == W-1)});
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m_ready"}, m_ready, 1);
        check({tag, "_m_sout"},  m_sout,  0);
        check({tag, "_m_valid"}, m_sv,    0);
        check({tag, "_m_last"},  m_sl,    0);
        check({tag, "_m_busy"},  m_busy,  0);
        check({tag, "_l_ready"}, l_ready, 1);
        check({tag, "_l_sout"},  l_sout,  0);
        check({tag, "_l_valid"}, l_sv,    0);
        check({tag, "_l_last"},  l_sl,    0);
        check({tag, "_l_busy"},  l_busy,  0);
    endtask

    // Offer a word and hold it until accepted; returns just after the accept edge
    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok        = 1'b0;
        din       = w;
        din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", ok, 1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            en = throttle ? (cyc % 3 == 0) : 1'b1;
        end
    end

    // Scoreboard: compare the bit on the wire, consume it on enabled edges
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("m_valid", m_sv,   qm.size() != 0);
                check("m_busy",  m_busy, qm.size() != 0);
                check("l_valid", l_sv,   ql.size() != 0);
                check("l_busy",  l_busy, ql.size() != 0);
                if (qm.size() != 0) begin
                    check("m_sout", m_sout, qm[0].b);
                    check("m_last", m_sl,   qm[0].last);
                end else begin
                    check("m_idle_sout", m_sout, 0);
                end
                if (ql.size() != 0) begin
                    check("l_sout", l_sout, ql[0].b);
                    check("l_last", l_sl,   ql[0].last);
                end else begin
                    check("l_idle_sout", l_sout, 0);
                end
                if (en && qm.size() != 0) begin
                    if (det_on) begin
                        hist  = {hist[2:0], m_sout};
                        nbits = nbits + 1;
                        if (nbits >= 4 && hist == 4'b1010) begin
                            if (npulse == 0) ppos0 = nbits;
                            if (npulse == 1) ppos1 = nbits;
                            npulse = npulse + 1;
                        end
                    end
                    void'(qm.pop_front());
                end
                if (en && ql.size() != 0) begin
                    void'(ql.pop_front());
                end
                if (din_valid && m_ready) begin
                    push_word(din);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        #1;
        check_reset("por");
        #21;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word, both bit orders
        send(8'h0D);
        repeat (10) @(posedge clk);
        #1;
        check("single_done_valid", m_sv,   0);
        check("single_done_busy",  m_busy, 0);
        check("single_done_sout",  m_sout, 0);

        // Back-to-back words into a 1010 detector
        det_on = 1'b1;
        hist   = '0;
        nbits  = 0;
        npulse = 0;
        send(8'hCA);
        send(8'h0A);
        @(negedge clk);
        check("b2b_hb_ready", m_ready, 0);
        repeat (3) @(negedge clk);
        check("b2b_hb_ready_hold", m_ready, 0);
        repeat (20) @(posedge clk);
        #1;
        det_on = 1'b0;
        check("det_bits",   nbits,  16);
        check("det_pulses", npulse, 2);
        check("det_pos0",   ppos0,  8);
        check("det_pos1",   ppos1,  16);

        // Throttled bit rate with a second word buffered mid-word
        throttle = 1'b1;
        send(8'h96);
        repeat (6) @(posedge clk);
        #1;
        send(8'h3C);
        @(negedge clk);
        check("thr_hb_ready", m_ready, 0);
        repeat (60) @(posedge clk);
        throttle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("thr_done_busy", m_busy, 0);

        // Offer a word in the last-bit cycle with the buffer empty
        send(8'hB5);
        repeat (7) @(posedge clk);
        #1;
        din       = 8'h4E;
        din_valid = 1'b1;
        @(negedge clk);
        check("bnd_last",  m_sl,    1);
        check("bnd_ready", m_ready, 1);
        @(posedge clk);
        #1;
        din       = 8'hE7;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(posedge clk);
        #3;
        check("rst_pre_hb_full", m_ready, 0);
        check("rst_pre_busy",    m_busy,  1);
        rst = 1'b0;
        #1;
        check_reset("midrst");
        qm.delete();
        ql.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(8'hF0);
        repeat (12) @(posedge clk);
        #1;
        check("final_valid", m_sv,   0);
        check("final_busy",  m_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/word_serializer.md
# word_serializer

Parallel-in, serial-out stage that sits directly upstream of the serial sequence detectors (the `1010` Mealy overlapping family). It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per enabled clock on `sout`, which connects straight to a detector's serial `in`. A one-word holding buffer behind the shift register allows back-to-back words to stream with no idle bit between them.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- IDLE_BIT, 0, value driven on `sout` whenever no word is being shifted.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  `din` holds a word.
- din_ready  out  1  the block can accept a word this cycle.
- en  in  1  bit-rate enable. Tie to 1 when driving a detector directly.
- sout  out  1  serial data bit.
- sout_valid  out  1  `sout` carries a word bit.
- sout_last  out  1  `sout` carries the final bit of a word.
- busy  out  1  the shift register or the holding buffer holds data.

## Operation
- Storage:
  - shift register SR (WIDTH bits);
  - holding buffer HB (WIDTH bits, flag `hb_full`);
  - bit counter `cnt` (clog2(WIDTH) bits, range 0..WIDTH-1).
- FSM states are IDLE and SHIFT. Reset state is IDLE with `cnt=0` and `hb_full=0`.
- Handshake:
  - A word is accepted on a rising edge when `din_valid && din_ready`.
  - `din_ready = !hb_full`, which is registered-state derived.
  - `din` is sampled only at acceptance.
- IDLE:
  - An accepted word loads SR directly, sets `cnt=0` and moves to SHIFT.
  - This happens regardless of `en`.
- SHIFT with `en=0`:
  - SR, `cnt` and `sout` hold.
  - An accepted word goes to HB and sets `hb_full`.
- SHIFT with `en=1` and `cnt<WIDTH-1`:
  - SR shifts one position toward the output end; `cnt` increments.
  - An accepted word goes to HB.
- SHIFT with `en=1` and `cnt==WIDTH-1` (word boundary), in priority order:
  - If `hb_full`: HB moves to SR, `hb_full` clears, `cnt=0`, stay in SHIFT. No accept is possible because `din_ready=0`.
  - Else if a word is accepted this edge: `din` loads SR directly, `cnt=0`, stay in SHIFT.
  - Else: go to IDLE.
- Output decode from registered state, with no combinational path from `din`/`din_valid`:
  - `sout` = SR[WIDTH-1] if MSB_FIRST, else SR[0], in SHIFT; IDLE_BIT in IDLE.
  - `sout_valid` = (state==SHIFT).
  - `sout_last` = (state==SHIFT) && (cnt==WIDTH-1).
  - `busy` = (state==SHIFT) || `hb_full`.
- Reset asserted mid-word:
  - SR and HB contents are discarded; the state goes to IDLE immediately, asynchronously.
  - After release, no partial word is ever resumed.

## Timing
- Reset values: `din_ready=1`, `sout=IDLE_BIT`, `sout_valid=0`, `sout_last=0`, `busy=0`.
- Latency: a word accepted in IDLE at edge k presents its first bit on `sout` in the cycle after edge k, i.e. one clock.
- Each bit is held for exactly one enabled cycle, so a word occupies WIDTH enabled cycles.
- Throughput is 1 bit per enabled cycle. Consecutive words are gapless if the next word is in HB, or is offered, by the boundary edge.
- `din_ready` falls in the cycle after HB fills. It rises in the cycle after the boundary edge that drains HB.
- Simultaneous accept and boundary with HB empty: the new word's first bit immediately follows the old word's last bit, with no IDLE cycle.
- With `en=1`, the downstream detector sees `sout` change on the same edges it samples on. Its `in` is valid whenever `sout_valid=1`.

## Test plan
- **Reset:** assert `rst=0` at any point.
  - Required: `din_ready=1`, `sout=IDLE_BIT`, `sout_valid=0`, `sout_last=0` and `busy=0`, all immediately and without a clock edge.
- **Single word, MSB-first:** WIDTH=8, MSB_FIRST=1, `en=1`, accept 8'h0D.
  - Required: `sout` = 0,0,0,0,1,1,0,1 on 8 consecutive cycles, with `sout_last` high only on the 8th cycle.
  - Required afterwards: `sout=0`, `sout_valid=0`, `busy=0`.
- **Single word, LSB-first:** MSB_FIRST=0, accept 8'h0D.
  - Required: `sout` = 1,0,1,1,0,0,0,0.
- **Back-to-back into a detector:** hold `din_valid=1` with 8'hCA then 8'h0A, `en=1`, and feed `sout` into a `1010` detector.
  - Required: 16 contiguous valid bits 1100101000001010.
  - Required: `din_ready=0` while HB is full.
  - Required: exactly 2 detector pulses, on bit 8 and bit 16.
- **Throttling:** pulse `en` every 3rd cycle and offer a second word mid-word.
  - Required: each bit is held 3 cycles and the second word is captured in HB (`din_ready` drops).
  - Required: the second word's first bit follows the first word's last bit after exactly one enabled edge.
- **Boundary accept and mid-word reset:**
  - Offer a word exactly in the `sout_last` cycle with HB empty. Required: no idle gap between words.
  - Then pulse `rst` low during bit 3 with HB full. Required: outputs return to reset values.
  - Then accept 8'hF0 after release. Required: it serializes cleanly as 1,1,1,1,0,0,0,0.
